// File: rtl/cnt_dly_gen2_if.sv
// rtl/cnt_dly_gen2_if.sv - control/status bundle for the counter/delay macrocell
// Groups every non-clock, non-reset signal of cnt_dly_gen2.
interface cnt_dly_gen2_if #(
   parameter int BIT_WIDTH = 14
) ();
   logic                 i_tick;
   logic [1:0]           i_mode;
   logic [1:0]           i_edge_sel;
   logic [BIT_WIDTH-1:0] i_data_from_register;
   logic                 i_in;
   logic                 i_up;
   logic                 i_keep;
   logic                 o_out;
   logic                 o_edge_detect_out;
   logic [BIT_WIDTH-1:0] o_count;

   modport master (
      output i_tick, i_mode, i_edge_sel, i_data_from_register, i_in, i_up, i_keep,
      input  o_out, o_edge_detect_out, o_count
   );

   modport slave (
      input  i_tick, i_mode, i_edge_sel, i_data_from_register, i_in, i_up, i_keep,
      output o_out, o_edge_detect_out, o_count
   );
endinterface

// File: rtl/cnt_dly_gen2.sv
// rtl/cnt_dly_gen2.sv - configurable delay / one-shot / counter / edge-detect macrocell
// Modes: 0 DLY (filtered delay), 1 ONESHOT, 2 CNT (free-running divider), 3 EDGE_DETECT.
module cnt_dly_gen2 #(
   parameter int BIT_WIDTH = 14,
   parameter int SYNC_IN   = 1
) (
   input  logic         i_clk,
   input  logic         i_reset,
   cnt_dly_gen2_if.slave bus
);

   localparam logic [1:0] M_DLY  = 2'd0;
   localparam logic [1:0] M_ONE  = 2'd1;
   localparam logic [1:0] M_CNT  = 2'd2;
   localparam logic [1:0] M_EDGE = 2'd3;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   logic                 s_in;
   logic                 s_q, s_dly_q;
   logic [1:0]           mode_q;
   state_t               state_q, state_d;
   logic [BIT_WIDTH-1:0] count_q, count_d;
   logic                 target_q, target_d;
   logic                 out_q, out_d;
   logic                 edge_q, edge_d;

   logic                 rise, fall, qe, nq, cnt_rst, mode_chg;
   logic [1:0]           sel;

   generate
      if (SYNC_IN != 0) begin : g_sync
         logic [1:0] sync_q;
         // two-flop synchroniser for the asynchronous trigger input
         always_ff @(posedge i_clk) begin
            if (i_reset) sync_q <= 2'b00;
            else         sync_q <= {sync_q[0], bus.i_in};
         end
         assign s_in = sync_q[1];
      end else begin : g_nosync
         assign s_in = bus.i_in;
      end
   endgenerate

   // edge classification, mode-change detection and next-state logic
   always_comb begin
      rise     = s_q & ~s_dly_q;
      fall     = ~s_q & s_dly_q;
      mode_chg = (bus.i_mode != mode_q);
      // level select only means something to the counter
      sel      = bus.i_edge_sel;
      if (bus.i_mode != M_CNT && sel == 2'd3) sel = 2'd0;
      case (sel)
         2'd0:    qe = rise | fall;
         2'd1:    qe = fall;
         default: qe = rise;
      endcase
      nq       = (sel == 2'd1 && rise) || (sel == 2'd2 && fall);
      cnt_rst  = (sel == 2'd3) ? s_q : qe;

      state_d  = state_q;
      count_d  = count_q;
      target_d = target_q;
      out_d    = out_q;
      edge_d   = qe;

      if (mode_chg) begin
         state_d = IDLE;
         count_d = '0;
         out_d   = 1'b0;
         edge_d  = 1'b0;
      end else begin
         case (bus.i_mode)
            M_DLY: begin
               if (qe) begin
                  // any qualifying edge (re)starts the run, filtering glitches
                  state_d  = RUN;
                  count_d  = '0;
                  target_d = s_q;
               end else if (nq) begin
                  state_d = IDLE;
                  out_d   = s_q;
               end else if (state_q == RUN && bus.i_tick) begin
                  if (count_q == bus.i_data_from_register) begin
                     out_d   = target_q;
                     state_d = IDLE;
                  end else begin
                     count_d = count_q + BIT_WIDTH'(1);
                  end
               end
            end
            M_ONE: begin
               if (state_q == IDLE) begin
                  if (qe) begin
                     out_d   = 1'b1;
                     count_d = '0;
                     state_d = RUN;
                  end
               end else if (bus.i_tick) begin
                  if (count_q == bus.i_data_from_register) begin
                     out_d   = 1'b0;
                     state_d = IDLE;
                  end else begin
                     count_d = count_q + BIT_WIDTH'(1);
                  end
               end
            end
            M_CNT: begin
               state_d = IDLE;
               out_d   = 1'b0;
               if (cnt_rst) begin
                  count_d = bus.i_up ? '0 : bus.i_data_from_register;
               end else if (bus.i_tick && !bus.i_keep) begin
                  if (bus.i_up) begin
                     if (count_q == bus.i_data_from_register) begin
                        count_d = '0;
                        out_d   = 1'b1;
                     end else begin
                        count_d = count_q + BIT_WIDTH'(1);
                     end
                  end else begin
                     if (count_q == '0) begin
                        count_d = bus.i_data_from_register;
                        out_d   = 1'b1;
                     end else begin
                        count_d = count_q - BIT_WIDTH'(1);
                     end
                  end
               end
            end
            default: begin
               state_d = IDLE;
               out_d   = qe;
            end
         endcase
      end
   end

   // state register; reset clears everything including the mode register
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         s_q      <= 1'b0;
         s_dly_q  <= 1'b0;
         mode_q   <= 2'd0;
         state_q  <= IDLE;
         count_q  <= '0;
         target_q <= 1'b0;
         out_q    <= 1'b0;
         edge_q   <= 1'b0;
      end else begin
         s_q      <= s_in;
         s_dly_q  <= s_q;
         mode_q   <= bus.i_mode;
         state_q  <= state_d;
         count_q  <= count_d;
         target_q <= target_d;
         out_q    <= out_d;
         edge_q   <= edge_d;
      end
   end

   assign bus.o_out             = out_q;
   assign bus.o_edge_detect_out = edge_q;
   assign bus.o_count           = count_q;

endmodule

// File: tb/tb_cnt_dly_gen2.sv
// tb/tb_cnt_dly_gen2.sv - self-checking bench for cnt_dly_gen2 (SYNC_IN=0)
module tb_cnt_dly_gen2;
   localparam int BW = 14;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cnt_dly_gen2_if #(.BIT_WIDTH(BW)) bus ();
   cnt_dly_gen2 #(.BIT_WIDTH(BW), .SYNC_IN(0)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));

   typedef struct {
      logic          out;
      logic          edg;
      logic [BW-1:0] cnt;
   } exp_t;
   exp_t sb[$];

   int n_checks = 0;
   int n_errs   = 0;

   // reference model state
   logic          m_s = 0, m_sd = 0, m_tgt = 0, m_out = 0, m_edg = 0, m_run = 0;
   logic [1:0]    m_mode = 0;
   logic [BW-1:0] m_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // reference model: compute the next register values from the inputs now applied
   task automatic model_step();
      logic rise, fall, qe, nq, rev;
      logic n_out, n_edg, n_run, n_tgt;
      logic [BW-1:0] n_cnt, d;
      int sel;
      exp_t e;
      d = bus.i_data_from_register;
      if (rst) begin
         m_s = 0; m_sd = 0; m_tgt = 0; m_out = 0; m_edg = 0; m_run = 0; m_mode = 0; m_cnt = 0;
      end else begin
         rise = m_s && !m_sd;
         fall = !m_s && m_sd;
         sel  = int'(bus.i_edge_sel);
         if (bus.i_mode != 2 && sel == 3) sel = 0;
         qe  = (sel == 0) ? (rise | fall) : (sel == 1) ? fall : rise;
         nq  = (sel == 1 && rise) || (sel == 2 && fall);
         rev = (sel == 3) ? m_s : qe;
         n_out = m_out; n_edg = qe; n_run = m_run; n_tgt = m_tgt; n_cnt = m_cnt;
         if (bus.i_mode != m_mode) begin
            n_run = 0; n_cnt = 0; n_out = 0; n_edg = 0;
         end else if (bus.i_mode == 0) begin
            if (qe) begin n_run = 1; n_cnt = 0; n_tgt = m_s; end
            else if (nq) begin n_run = 0; n_out = m_s; end
            else if (m_run && bus.i_tick) begin
               if (m_cnt == d) begin n_out = m_tgt; n_run = 0; end
               else n_cnt = m_cnt + 1'b1;
            end
         end else if (bus.i_mode == 1) begin
            if (!m_run) begin
               if (qe) begin n_out = 1; n_cnt = 0; n_run = 1; end
            end else if (bus.i_tick) begin
               if (m_cnt == d) begin n_out = 0; n_run = 0; end
               else n_cnt = m_cnt + 1'b1;
            end
         end else if (bus.i_mode == 2) begin
            n_run = 0; n_out = 0;
            if (rev) n_cnt = bus.i_up ? '0 : d;
            else if (bus.i_tick && !bus.i_keep) begin
               if (bus.i_up && m_cnt == d) begin n_cnt = 0; n_out = 1; end
               else if (bus.i_up) n_cnt = m_cnt + 1'b1;
               else if (m_cnt == 0) begin n_cnt = d; n_out = 1; end
               else n_cnt = m_cnt - 1'b1;
            end
         end else begin
            n_run = 0; n_out = qe;
         end
         m_sd = m_s; m_s = bus.i_in; m_mode = bus.i_mode;
         m_out = n_out; m_edg = n_edg; m_run = n_run; m_tgt = n_tgt; m_cnt = n_cnt;
      end
      e.out = m_out; e.edg = m_edg; e.cnt = m_cnt;
      sb.push_back(e);
   endtask

   // one clock: push expectation, clock the DUT, pop and compare
   task automatic cyc();
      exp_t e;
      model_step();
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         chk("o_out", 32'(bus.o_out), 32'(e.out));
         chk("o_edge", 32'(bus.o_edge_detect_out), 32'(e.edg));
         chk("o_count", 32'(bus.o_count), 32'(e.cnt));
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      int n, hi, seen, np, maxc, nbad, n16;
      int pulses[$];

      bus.i_tick = 0; bus.i_mode = 0; bus.i_edge_sel = 0; bus.i_data_from_register = 0;
      bus.i_in = 0; bus.i_up = 0; bus.i_keep = 0;
      rst = 1;
      run(2);
      chk("rst_out", 32'(bus.o_out), 32'd0);
      chk("rst_count", 32'(bus.o_count), 32'd0);
      rst = 0;

      // DLY rising delay and immediate fall on the non-qualifying edge
      bus.i_mode = 0; bus.i_edge_sel = 2; bus.i_data_from_register = 3; bus.i_tick = 1;
      run(2);
      bus.i_in = 1;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(); n++;
         if (bus.o_out) break;
      end
      chk("dly_rise_latency", 32'(n), 32'd6);
      run(3);
      bus.i_in = 0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(); n++;
         if (!bus.o_out) break;
      end
      chk("dly_fall_latency", 32'(n), 32'd2);

      // DLY glitch filtering
      bus.i_edge_sel = 0; bus.i_data_from_register = 5;
      run(3);
      bus.i_in = 1; run(2);
      bus.i_in = 0;
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         cyc();
         if (bus.o_out) seen = 1;
      end
      chk("dly_glitch_out", 32'(seen), 32'd0);

      // ONESHOT non-retriggerable width
      bus.i_mode = 1; bus.i_data_from_register = 2;
      run(3);
      bus.i_in = 1;
      hi = 0;
      for (int i = 0; i < 12; i++) begin
         if (i == 2) bus.i_in = 0;
         cyc();
         if (bus.o_out) hi++;
      end
      chk("oneshot_width", 32'(hi), 32'd3);

      // CNT down, tick every other cycle, 3 held ticks
      bus.i_mode = 2; bus.i_edge_sel = 0; bus.i_up = 0; bus.i_data_from_register = 4;
      for (int c = 0; c < 70; c++) begin
         bus.i_tick = (c % 2 == 0);
         bus.i_keep = (c >= 30 && c < 36);
         cyc();
         if (bus.o_out) pulses.push_back(c);
      end
      bus.i_keep = 0;
      nbad = 0; n16 = 0;
      for (int i = 1; i < pulses.size(); i++) begin
         if (pulses[i] - pulses[i-1] == 16) n16++;
         else if (pulses[i] - pulses[i-1] != 10) nbad++;
      end
      chk("cnt_period_bad", 32'(nbad), 32'd0);
      chk("cnt_stretch", 32'(n16), 32'd1);
      chk("cnt_pulses", 32'(pulses.size() >= 5), 32'd1);

      // CNT up, level reset held then released
      bus.i_tick = 1; bus.i_up = 1; bus.i_edge_sel = 3; bus.i_data_from_register = 7;
      bus.i_in = 1;
      run(3);
      np = 0; maxc = 0;
      for (int i = 0; i < 12; i++) begin
         cyc();
         if (bus.o_out) np++;
         if (int'(bus.o_count) > maxc) maxc = int'(bus.o_count);
      end
      chk("hold_pulses", 32'(np), 32'd0);
      chk("hold_count", 32'(maxc), 32'd0);
      bus.i_in = 0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(); n++;
         if (bus.o_out) break;
      end
      chk("up_first_pulse", 32'(n), 32'd9);

      // reset in the middle of a DLY run
      bus.i_mode = 0; bus.i_edge_sel = 2; bus.i_data_from_register = 5;
      run(3);
      bus.i_in = 1;
      n = 0;
      while (bus.o_count != 2 && n < 20) begin cyc(); n++; end
      chk("dly_reach_cnt2", 32'(bus.o_count), 32'd2);
      rst = 1; bus.i_in = 0;
      cyc();
      chk("midrst_out", 32'(bus.o_out), 32'd0);
      chk("midrst_edge", 32'(bus.o_edge_detect_out), 32'd0);
      chk("midrst_count", 32'(bus.o_count), 32'd0);
      rst = 0;
      run(8);

      // CNT -> EDGE_DETECT mode change mid-count
      bus.i_mode = 2; bus.i_up = 1; bus.i_edge_sel = 0; bus.i_data_from_register = 9;
      run(6);
      bus.i_mode = 3;
      cyc();
      chk("modechg_count", 32'(bus.o_count), 32'd0);
      for (int i = 0; i < 12; i++) begin
         bus.i_in = (i % 3 == 0);
         cyc();
         chk("edge_mode_out", 32'(bus.o_out), 32'(bus.o_edge_detect_out));
      end

      // randomised traffic against the model
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 29) == 0) bus.i_mode = 2'($urandom_range(0, 3));
         bus.i_edge_sel = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) bus.i_in = ~bus.i_in;
         bus.i_tick = ($urandom_range(0, 2) != 0);
         bus.i_up   = ($urandom_range(0, 7) != 0) ? bus.i_up : ~bus.i_up;
         bus.i_keep = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 19) == 0) bus.i_data_from_register = BW'($urandom_range(0, 4));
         rst = ($urandom_range(0, 199) == 0);
         cyc();
      end
      rst = 0;

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end
endmodule

// File: doc/cnt_dly_gen2.md
CNT_DLY_GEN2 -- requirements
Module: cnt_dly_gen2

Interface
REQ-001 The block SHALL have parameter BIT_WIDTH, default 14, giving the counter and data-register width; legal range is 2..32.
REQ-002 The block SHALL have parameter SYNC_IN, default 1; when 1, i_in passes through a 2-flop synchroniser before edge detection, and when 0 it passes through none.
REQ-003 The block SHALL have port i_clk  input  1  single clock; all flops update on its rising edge.
REQ-004 The block SHALL have port i_reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port i_tick  input  1  count strobe (prescaled clock enable); counters advance only in cycles where it is high.
REQ-006 The block SHALL have port i_mode  input  2  function select: 0 DLY, 1 ONESHOT, 2 CNT, 3 EDGE_DETECT.
REQ-007 The block SHALL have port i_edge_sel  input  2  edge select: 0 both edges, 1 falling, 2 rising, 3 high level (CNT only; treated as 0 in the other modes).
REQ-008 The block SHALL have port i_data_from_register  input  BIT_WIDTH  terminal value D.
REQ-009 The block SHALL have port i_in  input  1  trigger / reset input.
REQ-010 The block SHALL have port i_up  input  1  CNT direction: 1 up, 0 down.
REQ-011 The block SHALL have port i_keep  input  1  CNT hold: while high, count advance is suppressed.
REQ-012 The block SHALL have port o_out  output  1  registered macrocell output.
REQ-013 The block SHALL have port o_edge_detect_out  output  1  registered one-cycle pulse on each qualifying edge.
REQ-014 The block SHALL have port o_count  output  BIT_WIDTH  current counter value.

Function
REQ-015 The block SHALL derive the sampled input s from i_in after the synchroniser (if enabled) and keep s_d, s delayed by one cycle; rise = s & ~s_d, fall = ~s & s_d.
REQ-016 A qualifying edge (qe) SHALL be rise|fall, fall, rise or rise for i_edge_sel 0/1/2/3 respectively; o_edge_detect_out SHALL be high exactly in the cycle after qe.
REQ-017 The block SHALL use a two-state FSM, IDLE and RUN, for DLY and ONESHOT; in CNT and EDGE_DETECT the FSM SHALL stay in IDLE.
REQ-018 In DLY, when qe occurs: state <= RUN, count <= 0, target <= s; a qe during RUN SHALL restart the run with the new target (glitch filtering).
REQ-019 In DLY RUN, on each i_tick: if count == D then o_out <= target and state <= IDLE, otherwise count <= count+1; the delay is therefore D+1 ticks.
REQ-020 In DLY, an edge that does not qualify under i_edge_sel 1/2 SHALL abort any run (state <= IDLE) and set o_out <= s in the same update.
REQ-021 In ONESHOT, a qe in IDLE SHALL cause o_out <= 1, count <= 0, state <= RUN; on the i_tick where count == D, o_out <= 0 and state <= IDLE; qe during RUN SHALL be ignored (non-retriggerable).
REQ-022 In CNT down (i_up=0), each i_tick with i_keep=0 SHALL do: if count == 0 then count <= D and o_out pulses high for one cycle, else count <= count-1; the period is D+1 ticks.
REQ-023 In CNT up (i_up=1), each i_tick with i_keep=0 SHALL do: if count == D then count <= 0 and o_out pulses high for one cycle, else count <= count+1.
REQ-024 A CNT reset event SHALL be qe for i_edge_sel 0-2, or s==1 for i_edge_sel 3; it loads count <= D (down) or 0 (up), produces no pulse, and has priority over i_tick and i_keep.
REQ-025 With D == 0 in CNT, o_out SHALL pulse on every unheld i_tick; in DLY and ONESHOT, D == 0 SHALL give a 1-tick delay or width.
REQ-026 In EDGE_DETECT, o_out SHALL equal o_edge_detect_out.
REQ-027 Count arithmetic SHALL be modulo 2^BIT_WIDTH; wrap is reachable only through D and never through overflow.
REQ-028 The block SHALL register i_mode; when i_mode differs from the registered value, that cycle SHALL force state <= IDLE, count <= 0, o_out <= 0 and discard any qe.
REQ-029 o_count SHALL present the count register directly.

Reset
REQ-030 While i_reset is high at a rising edge of i_clk, the following SHALL clear to 0: count, state (IDLE), target, o_out, o_edge_detect_out, s, s_d, synchroniser flops and the mode register; reset has priority over all other events.
REQ-031 After reset, the first unheld i_tick in CNT down mode SHALL produce an o_out pulse and load D, because count resets to 0.

Verification
REQ-032 DLY, sel=2, D=3, i_tick every cycle, SYNC_IN=0: i_in rises -> o_out rises 4 ticks after qe; i_in then falls -> o_out falls the next cycle.
REQ-033 DLY, sel=0, D=5: a 2-cycle high glitch on i_in -> o_out stays 0 and o_count restarts at each edge.
REQ-034 ONESHOT, D=2: rising edge, then a second edge 1 tick later -> o_out is high for exactly 3 ticks and the second edge is ignored.
REQ-035 CNT down, D=4, i_tick every 2 cycles: o_out pulses every 10 cycles; raising i_keep for 3 ticks stretches one period by 6 cycles.
REQ-036 CNT up, sel=3, D=7: i_in held high -> o_count stays at 0 with no pulses; release -> first pulse after 8 ticks.
REQ-037 i_reset asserted mid-DLY run (count=2) -> next cycle all outputs 0 and state IDLE; a mode change from CNT to EDGE_DETECT mid-count -> o_count = 0 the next cycle.
